inst_pair_queue: RTL and testbench
==================================

# inst_pair_queue

Dual-lane instruction queue between the fetch stage and the dual-issue launch stage. It accepts up to two fetched instructions per cycle and presents the two oldest instructions as launch line1 and line2. The launch stage reports how many of them it took (0, 1 or 2), which absorbs single-issue stalls without replaying fetch. Branch and exception flushes empty the queue.

## Interface
Parameters:
- DEPTH, 8: number of single-instruction entries; power of two, at least 4.
- ENTRY_W, 64: width of one entry, {pc[63:32], inst[31:0]} with the default value.

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- line1_pre_to_now_valid_i  input  1  fetch lane 1 holds a valid instruction.
- line2_pre_to_now_valid_i  input  1  fetch lane 2 holds a valid instruction.
- pre_to_ibus  input  2*ENTRY_W  {lane2, lane1} fetch payload.
- now_allowin_o  output  1  queue can accept a two-instruction push this cycle.
- deq_cnt_i  input  2  instructions consumed by launch this cycle: 0, 1 or 2. Value 3 is treated as 2.
- line1_now_to_next_valid_o  output  1  line1 output holds the oldest entry.
- line2_now_to_next_valid_o  output  1  line2 output holds the second-oldest entry.
- to_next_obus  output  2*ENTRY_W  {line2, line1} payload. A lane that is not valid drives all zeros.
- branch_flush_i  input  1  branch redirect; clear the queue.
- excep_flush_i  input  1  exception redirect; clear the queue.
- count_o  output  $clog2(DEPTH)+1  current occupancy, for debug and performance counters.

## Operation
- State: head pointer, tail pointer (both $clog2(DEPTH) bits, wrapping modulo DEPTH), occupancy count, and DEPTH x ENTRY_W storage. Storage is not reset.
- Push acceptance:
  - A push is accepted only when now_allowin_o is 1.
  - now_allowin_o = (count <= DEPTH-2), evaluated from the current registered count only.
  - It does not look ahead to the same-cycle dequeue.
- Push compaction:
  - push_n = lane1 valid + lane2 valid.
  - Lane1 is written at tail, then lane2 at tail+1.
  - If only lane2 is valid, it is written at tail.
  - tail advances by push_n.
- Dequeue:
  - pop_n = min(deq_cnt_i, count); an over-request is silently clamped.
  - head advances by pop_n.
- Outputs:
  - line1 valid = (count >= 1), data = storage[head].
  - line2 valid = (count >= 2), data = storage[head+1 mod DEPTH].
  - Both are driven combinationally from registered state, with no bypass from pre_to_ibus.
- Count update: count_next = count + push_n - pop_n. Simultaneous push and pop in one cycle is legal.
- Flush:
  - If branch_flush_i or excep_flush_i is 1 at a rising edge, then head, tail and count all become 0.
  - The same-cycle push and pop are discarded.
  - Flush has priority over every other event, including when both flush inputs are asserted together.
- Single-issue stall: deq_cnt_i=1 moves the old line2 entry to line1 next cycle, and the following entry, if any, becomes line2.
- Wrap-around: entries straddling index DEPTH-1 to 0 are read and written correctly.

## Timing
- Reset (async assert): head=0, tail=0, count=0, line1/line2 valid=0, to_next_obus=0, now_allowin_o=1, count_o=0.
- Latency: an entry pushed at rising edge N is visible at the outputs during the cycle after edge N, which is a 1-cycle minimum fetch-to-launch latency.
- Throughput: 2 instructions per cycle sustained when deq_cnt_i=2 every cycle.
- Flush recovery: outputs are invalid in the cycle after the flush edge, and now_allowin_o=1 in that cycle.
- Reset asserted mid-operation: state clears immediately without waiting for a clock edge. Contents are lost.

## Test plan
- Reset, then push {A,B} for one cycle with deq_cnt_i=0:
  - required: next cycle line1=A, line2=B, both valid, count_o=2.
  - required: now_allowin_o=1 with DEPTH=8.
- Fill with 8 entries while deq_cnt_i=0:
  - required: now_allowin_o drops to 0 once count_o=7.
  - required: a further push with now_allowin_o=0 leaves count unchanged.
- Queue holds A,B,C. Set deq_cnt_i=1, then deq_cnt_i=2:
  - required after the first edge: line1=B, line2=C.
  - required after the second edge: count_o=0, both lanes invalid, data zero.
- Push and pop 2 per cycle for 10 cycles to force wrap-around:
  - required: output order exactly matches input order.
  - required: count_o stays constant.
- With count_o=5, push {X,Y} and deq_cnt_i=2, while branch_flush_i=1 at the same edge:
  - required: count_o=0, head=tail=0, X and Y absent.
  - Repeat with excep_flush_i; same result required.
- With count_o=1, apply deq_cnt_i=2 and a lane2-only push Z:
  - required: count_o=1, line1=Z, line2 invalid.

Source files
------------

// File: rtl/inst_pair_queue.sv
// inst_pair_queue: dual-lane instruction queue between fetch and dual-issue launch.
// Accepts up to two fetched instructions per cycle, presents the two oldest to
// launch, and retires 0/1/2 per cycle as reported by the launch stage.
module inst_pair_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       line1_pre_to_now_valid_i,
    input  logic                       line2_pre_to_now_valid_i,
    input  logic [2*ENTRY_W-1:0]       pre_to_ibus,
    output logic                       now_allowin_o,
    input  logic [1:0]                 deq_cnt_i,
    output logic                       line1_now_to_next_valid_o,
    output logic                       line2_now_to_next_valid_o,
    output logic [2*ENTRY_W-1:0]       to_next_obus,
    input  logic                       branch_flush_i,
    input  logic                       excep_flush_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    logic               w_flush;
    logic               w_allowin;
    logic               w_wr1;
    logic               w_wr2;
    logic [1:0]         w_push_n;
    logic [1:0]         w_deq_req;
    logic [1:0]         w_pop_n;
    logic [AW-1:0]      w_wr2_idx;
    logic [AW-1:0]      w_head1;

    assign w_flush   = branch_flush_i | excep_flush_i;

    // Room for a full pair, judged on the registered count only (no same-cycle pop credit).
    assign w_allowin = (r_count <= CW'(DEPTH - 2));

    assign w_wr1     = line1_pre_to_now_valid_i & w_allowin;
    assign w_wr2     = line2_pre_to_now_valid_i & w_allowin;
    assign w_push_n  = {1'b0, w_wr1} + {1'b0, w_wr2};

    // A request of 3 means "take both"; requests beyond occupancy are clamped.
    assign w_deq_req = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
    assign w_pop_n   = (r_count >= CW'(2))        ? w_deq_req :
                       (CW'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;

    // Lane2 compacts down to tail when lane1 is empty.
    assign w_wr2_idx = w_wr1 ? (r_tail + AW'(1)) : r_tail;
    assign w_head1   = r_head + AW'(1);

    // Pointer and occupancy update; flush dominates push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Entry storage; not reset, writes dropped on a flush cycle.
    always_ff @(posedge clk) begin
        if (!w_flush) begin
            if (w_wr1) r_mem[r_tail]    <= pre_to_ibus[ENTRY_W-1:0];
            if (w_wr2) r_mem[w_wr2_idx] <= pre_to_ibus[2*ENTRY_W-1:ENTRY_W];
        end
    end

    // Launch-side view of the two oldest entries; invalid lanes read as zero.
    always_comb begin
        line1_now_to_next_valid_o = (r_count >= CW'(1));
        line2_now_to_next_valid_o = (r_count >= CW'(2));
        to_next_obus              = '0;
        if (line1_now_to_next_valid_o) to_next_obus[ENTRY_W-1:0]         = r_mem[r_head];
        if (line2_now_to_next_valid_o) to_next_obus[2*ENTRY_W-1:ENTRY_W] = r_mem[w_head1];
    end

    assign now_allowin_o = w_allowin;
    assign count_o       = r_count;

endmodule

// File: tb/tb_inst_pair_queue.sv
// Directed self-checking bench for inst_pair_queue (DEPTH=8, ENTRY_W=64).
module tb_inst_pair_queue;

    logic         clk;
    logic         rst_n;
    logic         v1_i;
    logic         v2_i;
    logic [127:0] pre_to_ibus;
    logic         allowin;
    logic [1:0]   deq_cnt;
    logic         v1_o;
    logic         v2_o;
    logic [127:0] to_next_obus;
    logic         bflush;
    logic         eflush;
    logic [3:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_pair_queue #(.DEPTH(8), .ENTRY_W(64)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .line1_pre_to_now_valid_i  (v1_i),
        .line2_pre_to_now_valid_i  (v2_i),
        .pre_to_ibus               (pre_to_ibus),
        .now_allowin_o             (allowin),
        .deq_cnt_i                 (deq_cnt),
        .line1_now_to_next_valid_o (v1_o),
        .line2_now_to_next_valid_o (v2_o),
        .to_next_obus              (to_next_obus),
        .branch_flush_i            (bflush),
        .excep_flush_i             (eflush),
        .count_o                   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ent(input int n);
        return {32'h0000_1000 + 32'(n) * 32'd4, 32'hA5A5_0000 + 32'(n)};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int cnt, input bit ev1, input bit ev2,
                           input logic [63:0] d1, input logic [63:0] d2);
        check({tag, ".count"}, 128'(count), 128'(cnt));
        check({tag, ".v1"},    128'(v1_o),  128'(ev1));
        check({tag, ".v2"},    128'(v2_o),  128'(ev2));
        check({tag, ".line1"}, 128'(to_next_obus[63:0]),   128'(d1));
        check({tag, ".line2"}, 128'(to_next_obus[127:64]), 128'(d2));
    endtask

    // Drive one cycle of stimulus, take the edge, sample 1 time unit later, idle inputs.
    task automatic step(input bit a1, input bit a2, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [1:0] deq, input bit bf, input bit ef);
        v1_i        = a1;
        v2_i        = a2;
        pre_to_ibus = {d2, d1};
        deq_cnt     = deq;
        bflush      = bf;
        eflush      = ef;
        @(posedge clk);
        #1;
        v1_i        = 1'b0;
        v2_i        = 1'b0;
        pre_to_ibus = '0;
        deq_cnt     = 2'd0;
        bflush      = 1'b0;
        eflush      = 1'b0;
    endtask

    task automatic build5(input int base);
        step(1, 1, ent(base),     ent(base + 1), 0, 0, 0);
        step(1, 1, ent(base + 2), ent(base + 3), 0, 0, 0);
        step(1, 0, ent(base + 4), 64'd0,         0, 0, 0);
        check("build5.count", 128'(count), 128'd5);
    endtask

    initial begin
        rst_n       = 1'b0;
        v1_i        = 1'b0;
        v2_i        = 1'b0;
        pre_to_ibus = '0;
        deq_cnt     = 2'd0;
        bflush      = 1'b0;
        eflush      = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 64'd0, 64'd0);
        check("reset.allowin", 128'(allowin), 128'd1);
        #1 rst_n = 1'b1;

        // Pair push visible next cycle
        step(1, 1, ent(1), ent(2), 0, 0, 0);
        chk_out("push_ab", 2, 1, 1, ent(1), ent(2));
        check("push_ab.allowin", 128'(allowin), 128'd1);

        // Fill toward full
        step(1, 1, ent(3), ent(4), 0, 0, 0);
        step(1, 1, ent(5), ent(6), 0, 0, 0);
        check("fill6.count", 128'(count), 128'd6);
        check("fill6.allowin", 128'(allowin), 128'd1);
        step(1, 0, ent(7), 64'd0, 0, 0, 0);
        check("fill7.count", 128'(count), 128'd7);
        check("fill7.allowin", 128'(allowin), 128'd0);
        step(1, 1, ent(8), ent(9), 0, 0, 0);
        chk_out("refused", 7, 1, 1, ent(1), ent(2));
        step(0, 0, 64'd0, 64'd0, 1, 0, 0);
        chk_out("pop1", 6, 1, 1, ent(2), ent(3));
        check("pop1.allowin", 128'(allowin), 128'd1);
        step(1, 1, ent(10), ent(11), 0, 0, 0);
        chk_out("full8", 8, 1, 1, ent(2), ent(3));
        check("full8.allowin", 128'(allowin), 128'd0);

        // Drain in pairs; e10/e11 straddle index 7 -> 0
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);
        chk_out("drain1", 6, 1, 1, ent(4), ent(5));
        step(0, 0, 64'd0, 64'd0, 3, 0, 0);
        chk_out("drain2_deq3", 4, 1, 1, ent(6), ent(7));
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);
        chk_out("drain3_wrap", 2, 1, 1, ent(10), ent(11));
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);
        chk_out("drain4", 0, 0, 0, 64'd0, 64'd0);

        // Single-issue stall then double pop
        step(1, 1, ent(20), ent(21), 0, 0, 0);
        step(1, 0, ent(22), 64'd0, 0, 0, 0);
        chk_out("abc", 3, 1, 1, ent(20), ent(21));
        step(0, 0, 64'd0, 64'd0, 1, 0, 0);
        chk_out("stall", 2, 1, 1, ent(21), ent(22));
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);
        chk_out("abc_empty", 0, 0, 0, 64'd0, 64'd0);

        // Sustained 2-in / 2-out with wrap-around
        step(1, 1, ent(30), ent(31), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, ent(40 + 2 * i), ent(41 + 2 * i), 2, 0, 0);
            chk_out("stream", 2, 1, 1, ent(40 + 2 * i), ent(41 + 2 * i));
        end
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);
        chk_out("stream_end", 0, 0, 0, 64'd0, 64'd0);

        // Branch flush with concurrent push and pop
        build5(50);
        step(1, 1, ent(60), ent(61), 2, 1, 0);
        chk_out("bflush", 0, 0, 0, 64'd0, 64'd0);
        check("bflush.allowin", 128'(allowin), 128'd1);
        step(1, 0, ent(62), 64'd0, 0, 0, 0);
        chk_out("bflush_recover", 1, 1, 0, ent(62), 64'd0);
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);

        // Exception flush
        build5(80);
        step(1, 1, ent(90), ent(91), 2, 0, 1);
        chk_out("eflush", 0, 0, 0, 64'd0, 64'd0);
        check("eflush.allowin", 128'(allowin), 128'd1);
        step(1, 1, ent(92), ent(93), 0, 0, 0);
        chk_out("eflush_recover", 2, 1, 1, ent(92), ent(93));
        step(0, 0, 64'd0, 64'd0, 2, 0, 0);

        // Both flushes together
        build5(100);
        step(1, 1, ent(110), ent(111), 1, 1, 1);
        chk_out("both_flush", 0, 0, 0, 64'd0, 64'd0);

        // Over-request clamp plus lane2-only push
        step(1, 0, ent(70), 64'd0, 0, 0, 0);
        chk_out("one", 1, 1, 0, ent(70), 64'd0);
        step(0, 1, 64'd0, ent(71), 2, 0, 0);
        chk_out("lane2_only", 1, 1, 0, ent(71), 64'd0);

        // Asynchronous reset mid-cycle
        step(1, 1, ent(120), ent(121), 0, 0, 0);
        check("pre_areset.count", 128'(count), 128'd3);
        #3 rst_n = 1'b0;
        #2;
        chk_out("areset", 0, 0, 0, 64'd0, 64'd0);
        check("areset.allowin", 128'(allowin), 128'd1);
        #2 rst_n = 1'b1;
        step(0, 1, 64'd0, ent(130), 0, 0, 0);
        chk_out("post_areset", 1, 1, 0, ent(130), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
